// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access-size codes,
// controller states, memory write-enable codes and alignment helpers.
package lsu_pkg;

  // Access size encodings carried on req_size (3 is reserved and behaves as a word)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Memory write-enable codes; the unit only ever issues full-word writes
  localparam logic [1:0] WE_NONE = 2'd0;
  localparam logic [1:0] WE_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Word and the reserved code both move a full 32-bit word
  function automatic logic is_word_size(input logic [1:0] size);
    return (size == SZ_W) || (size == 2'd3);
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_H) && addr_lo[0]) || (is_word_size(size) && (addr_lo != 2'd0));
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake and memory-side bus of the load/store unit.
// Optional macro LSU_MISALIGN_TRAP_EN adds the rsp_err response flag.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  // Pipeline request side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  // Completion side
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              rsp_err;
`endif
  // Word-addressed data memory side
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_we;
  logic [31:0]       mem_rdata;

  // Upstream pipeline plus the memory model sit on the master side
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    input  rsp_err,
`endif
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

  // The load/store unit itself
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output rsp_err,
`endif
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: picks and extends the load lane out of a word,
// and merges store data into the addressed lane of an old word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] base,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Load path: select the lane, then sign- or zero-extend it
  always_comb begin
    byte_v = base[7:0];
    case (addr_lo)
      2'd1:    byte_v = base[15:8];
      2'd2:    byte_v = base[23:16];
      2'd3:    byte_v = base[31:24];
      default: byte_v = base[7:0];
    endcase
    half_v = addr_lo[1] ? base[31:16] : base[15:0];
    case (size)
      SZ_B:    load_data = uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    load_data = uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data = base;
    endcase
  end

  // Store path: each byte lane either takes new data or keeps the old byte
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic       sel;
    logic [7:0] src;

    // Decide whether this lane is written and which store byte feeds it
    always_comb begin
      case (size)
        SZ_B: begin
          sel = (addr_lo == LANE);
          src = wdata[7:0];
        end
        SZ_H: begin
          sel = (addr_lo[1] == LANE[1]);
          src = LANE[0] ? wdata[15:8] : wdata[7:0];
        end
        default: begin
          sel = 1'b1;
          src = wdata[8*gi +: 8];
        end
      endcase
    end

    assign merged[8*gi +: 8] = sel ? src : base[8*gi +: 8];
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the word-addressed data memory. Sub-word
// stores are done as read-modify-write so memory only sees full words.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word requests
// complete immediately with rsp_err=1 and no memory access.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int IDX_W     = 10
) (
  input logic         clk,
  input logic         rst,
  lsu_mem_ctrl_if.slave bus
);

  if (MEM_DEPTH != (1 << IDX_W)) begin : g_depth_check
    $error("MEM_DEPTH must equal 2**IDX_W");
  end

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [IDX_W+1:0]  addr_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       old_reg;
  logic [31:0]       rdata_reg;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              err_reg;
`endif

  logic              accept;
  logic              trap_hit;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       lane_base;
  logic [31:0]       load_data;
  logic [31:0]       merged;

  logic              req_ready_c;
  logic              rsp_valid_c;
  logic [1:0]        mem_we_c;
  logic [31:0]       mem_addr_c;
  logic [31:0]       mem_wdata_c;

  // Address bits above the memory window are deliberately ignored (wrap)
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W+2];

  assign accept = (state_reg == IDLE) && bus.req_valid;
  assign idx    = addr_reg[IDX_W+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  // In RD the old word is live on mem_rdata; in WR it comes from the capture
  assign lane_base = (state_reg == RD) ? bus.mem_rdata : old_reg;

  lsu_lane_align u_align (
    .size      (size_reg),
    .uns       (uns_reg),
    .addr_lo   (addr_reg[1:0]),
    .base      (lane_base),
    .wdata     (wdata_reg),
    .load_data (load_data),
    .merged    (merged)
  );

  // State register; reset drops straight to IDLE so any pending write dies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and state-decoded memory/handshake outputs
  always_comb begin
    state_next  = state_reg;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    mem_we_c    = WE_NONE;
    mem_addr_c  = 32'd0;
    mem_wdata_c = 32'd0;
    case (state_reg)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          if (trap_hit)
            state_next = DONE;
          else if (bus.req_we && is_word_size(bus.req_size))
            state_next = WR;
          else
            state_next = RD;
        end
      end
      RD: begin
        mem_addr_c = {{(32-IDX_W){1'b0}}, idx};
        // Present the merge result already, so mem_wdata is steady into WR
        if (we_reg) mem_wdata_c = merged;
        state_next = we_reg ? WR : DONE;
      end
      WR: begin
        mem_addr_c  = {{(32-IDX_W){1'b0}}, idx};
        mem_we_c    = WE_WORD;
        mem_wdata_c = merged;
        state_next  = DONE;
      end
      DONE: begin
        rsp_valid_c = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, old-word capture and load result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_reg    <= 1'b0;
      size_reg  <= SZ_B;
      uns_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      old_reg   <= 32'd0;
      rdata_reg <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_reg    <= bus.req_we;
        size_reg  <= bus.req_size;
        uns_reg   <= bus.req_unsigned;
        addr_reg  <= bus.req_addr[IDX_W+1:0];
        wdata_reg <= bus.req_wdata;
        // A trapped load reports zero data
        if (trap_hit && !bus.req_we) rdata_reg <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
        err_reg   <= trap_hit;
`endif
      end
      if (state_reg == RD) begin
        old_reg <= bus.mem_rdata;
        if (!we_reg) rdata_reg <= load_data;
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  // Stores complete with zero data; the last load result is otherwise held
  assign bus.rsp_rdata = (rsp_valid_c && we_reg) ? 32'd0 : rdata_reg;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.rsp_err   = rsp_valid_c && err_reg;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a word-addressed memory model.
// Build with LSU_MISALIGN_TRAP_EN defined to cover the misalignment trap.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_mem_ctrl #(.ADDR_W(32), .MEM_DEPTH(1024), .IDX_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, word write on mem_we=3
  logic [31:0] mem [0:1023];
  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];
  always @(posedge clk) if (bus.mem_we == 2'd3) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request: latency counted from accept edge, write activity recorded
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output int lat, output logic [31:0] rdata, output int wes,
                     output logic [31:0] waddr, output logic [31:0] wd, output logic err);
    @(negedge clk);
    bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; wes = 0; waddr = 32'd0; wd = 32'd0; err = 1'b0;
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.mem_we !== 2'd0) begin wes++; waddr = bus.mem_addr; wd = bus.mem_wdata; end
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.rsp_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
    err = bus.rsp_err;
`endif
    $display("TXN we=%0d size=%0d uns=%0d addr=%h wdata=%h lat=%0d rdata=%h wes=%0d waddr=%h mwdata=%h err=%0d",
             we, size, uns, addr, wdata, lat, rdata, wes, waddr, wd, err);
    @(posedge clk); #1;
  endtask

  int          lat, wes;
  logic [31:0] rd, wa, wd;
  logic        er;

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

    // Reset state
    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Word store then word load
    txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, wes, wa, wd, er);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_we_cycles", 32'(wes), 32'd1);
    chk("sw_mem_addr", wa, 32'd4);
    chk("sw_mem_wdata", wd, 32'hDEADBEEF);
    chk("sw_rsp_rdata", rd, 32'd0);
    txn(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, lat, rd, wes, wa, wd, er);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_we_cycles", 32'(wes), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_err", 32'(er), 32'd0);
`endif
    chk("idle_mem_addr", bus.mem_addr, 32'd0);

    // Sub-word store read-modify-write
    txn(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, lat, rd, wes, wa, wd, er);
    txn(1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AB, lat, rd, wes, wa, wd, er);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_we_cycles", 32'(wes), 32'd1);
    chk("sb_mem_addr", wa, 32'd8);
    chk("sb_mem_wdata", wd, 32'h11AB3344);
    txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, lat, rd, wes, wa, wd, er);
    chk("sb_readback", rd, 32'h11AB3344);

    // Load extension on 0x8000F0FF
    txn(1'b1, 2'd2, 1'b0, 32'h30, 32'h8000F0FF, lat, rd, wes, wa, wd, er);
    txn(1'b0, 2'd0, 1'b0, 32'h30, 32'd0, lat, rd, wes, wa, wd, er);
    chk("lb_30", rd, 32'hFFFFFFFF);
    txn(1'b0, 2'd0, 1'b1, 32'h30, 32'd0, lat, rd, wes, wa, wd, er);
    chk("lbu_30", rd, 32'h000000FF);
    txn(1'b0, 2'd0, 1'b0, 32'h31, 32'd0, lat, rd, wes, wa, wd, er);
    chk("lb_31", rd, 32'hFFFFFFF0);
    txn(1'b0, 2'd1, 1'b0, 32'h32, 32'd0, lat, rd, wes, wa, wd, er);
    chk("lh_32", rd, 32'hFFFF8000);
    txn(1'b0, 2'd1, 1'b1, 32'h32, 32'd0, lat, rd, wes, wa, wd, er);
    chk("lhu_32", rd, 32'h00008000);

    // Half store into the upper half, low half preserved
    txn(1'b1, 2'd1, 1'b0, 32'h32, 32'hFFFF1234, lat, rd, wes, wa, wd, er);
    chk("sh_mem_wdata", wd, 32'h1234F0FF);

    // Address wrap modulo 4 KiB
    txn(1'b1, 2'd2, 1'b0, 32'h1004, 32'h5A5A1234, lat, rd, wes, wa, wd, er);
    chk("wrap_mem_addr", wa, 32'd1);
    txn(1'b0, 2'd2, 1'b0, 32'h0004, 32'd0, lat, rd, wes, wa, wd, er);
    chk("wrap_readback", rd, 32'h5A5A1234);

    // Reset while an SB is in WR: write must be suppressed
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h21; bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_wr", 32'(bus.mem_we), 32'd3);
    rst = 1'b0;
    #1;
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    $display("TXN abort SB addr=00000021 during WR");
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    txn(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, lat, rd, wes, wa, wd, er);
    chk("abort_readback", rd, 32'h11AB3344);

    // Misaligned word load
    txn(1'b0, 2'd2, 1'b0, 32'h13, 32'd0, lat, rd, wes, wa, wd, er);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_we_cycles", 32'(wes), 32'd0);
`else
    chk("mis_lat", 32'(lat), 32'd2);
    chk("mis_rdata", rd, 32'hDEADBEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit sitting directly upstream of the word-addressed data memory in the RISC-V core's MEM stage.
- Accepts byte/half/word load and store requests from the EX/MEM pipeline over a valid/ready handshake.
- Converts byte addresses to word indices and extracts/sign-extends load data.
- Performs read-modify-write for sub-word stores, so the memory only ever receives full-word writes (RWE=3).

Parameters:
ADDR_W, 32, request byte-address width
MEM_DEPTH, 1024, memory depth in 32-bit words; power of two
IDX_W, 10, log2(MEM_DEPTH); width of the word index actually driven

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
req_unsigned  input  1  zero-extend load (LBU/LHU)
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
rsp_valid  output  1  one-cycle completion pulse (loads and stores)
rsp_rdata  output  32  extended load data; 0 for stores
mem_addr  output  32  word index to memory, upper bits zero
mem_wdata  output  32  full word to write
mem_we  output  2  memory write enable: 0 = none, 3 = word write; 1/2 never driven
mem_rdata  input  32  combinational read data of mem_addr

Behaviour:
- Reset (async, rst=0):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; mem_we=0; mem_addr=0; mem_wdata=0; latched request cleared.
  - Reset mid-operation aborts the access. mem_we is decoded from state, so no write occurs after rst falls.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/size/unsigned/addr/wdata.
  - Load or sub-word store -> RD. Word store -> WR.
- RD:
  - mem_addr = latched index, mem_we=0.
  - At clk edge, capture mem_rdata.
  - Load: extract lane, extend, register into rsp_rdata -> DONE.
  - Sub-word store: keep old word -> WR.
- WR:
  - mem_we=3 for exactly one cycle.
  - mem_wdata = req_wdata for word stores; otherwise the old word with the addressed lane replaced.
  - Next state -> DONE.
- DONE: rsp_valid=1 for one cycle, req_ready=0 -> IDLE. rsp_rdata holds until the next load completes.
- Latency (accept edge to rsp_valid): load 2 cycles; word store 2; sub-word store 3. One request in flight; throughput one request per 3–4 cycles.
- Index: mem_addr = req_addr[IDX_W+1:2]; higher address bits ignored, so addresses wrap modulo MEM_DEPTH*4.
- Lane select, byte: addr[1:0] selects byte k = bits [8k+7:8k].
- Lane select, half:
  - addr[1] selects the half.
  - addr[0] ignored (aligned down).
- Word: addr[1:0] ignored.
- Load extension: sign-extend from bit 7/15 unless req_unsigned; req_unsigned ignored for word.
- Store merge: only the addressed 8/16 bits change; other bytes of the old word are preserved bit-exact.
- req_valid while not in IDLE is ignored; upstream must hold the request until the req_valid&&req_ready edge.
- mem_addr/mem_wdata are held stable from RD through WR; both are 0 in IDLE.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined:
  - Adds output rsp_err (1 bit, reset 0).
  - A misaligned request goes IDLE -> DONE with no memory access: half with addr[0]=1, or word with addr[1:0]!=0.
  - In that case rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - rsp_err=0 for all aligned completions.
- Undefined: no rsp_err port; misaligned addresses are silently aligned down as above.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W;
  - state enum (IDLE/RD/WR/DONE);
  - memory write-enable constants WE_NONE=0, WE_WORD=3.
- Sub-module lsu_lane_align (combinational):
  - load path: extract + extend;
  - store path: lane merge.
- FSM and registers stay in lsu_mem_ctrl.

Test Plan:
- Word store addr=0x10, wdata=0xDEADBEEF, then LW 0x10 -> mem_we=3 one cycle with mem_addr=4; rsp_rdata=0xDEADBEEF two cycles after accept.
- Word 0x11223344 at 0x20; SB addr=0x22 wdata=0xAB -> RD then WR; mem_wdata=0x11AB3344; rsp_valid 3 cycles after accept.
- Word 0x8000F0FF at 0x30:
  - LB 0x30 -> 0xFFFFFFFF; LBU 0x30 -> 0x000000FF;
  - LH 0x32 -> 0xFFFF8000; LHU 0x32 -> 0x00008000.
- Byte address wrap, MEM_DEPTH=1024: SW to 0x1004 -> mem_addr=1; LW 0x0004 returns the same data.
- Reset mid-op: assert rst=0 while in WR of an SB; mem_we=0 immediately, req_ready=1, rsp_valid=0; the target word is unchanged on readback.
- LSU_MISALIGN_TRAP_EN: LW addr=0x13 -> rsp_valid=1, rsp_err=1 on the 2nd cycle, mem_we never asserted. Without the macro: same request reads word index 4.
